// File: rtl/lfsr10_pkg.sv
// Shared definitions for the 10-bit XNOR LFSR (taps 10 and 7, new bit enters sh[1]).
// Used by both the stream generator and the receive-side checker.
package lfsr10_pkg;

  localparam int LFSR_W = 10;
  localparam int TAP_A  = 10;
  localparam int TAP_B  = 7;

  typedef enum logic [1:0] {
    FILL,
    VERIFY,
    LOCKED
  } state_t;

  // XNOR feedback; the all-ones register is the lock-up state that maps onto itself.
  function automatic logic lfsr10_next_bit(input logic [LFSR_W:1] s);
    return ~(s[TAP_A] ^ s[TAP_B]);
  endfunction

endpackage

// File: rtl/lfsr10_checker.sv
// Self-synchronising receive checker for the 10-bit XNOR LFSR stream: fills, verifies,
// locks, then counts prediction mismatches and drops lock after sustained errors.
module lfsr10_checker
  import lfsr10_pkg::*;
#(
  parameter int unsigned LOCK_CNT  = 16,
  parameter int unsigned LOSS_ERRS = 4,
  parameter int unsigned ERR_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_valid,
  input  logic             bit_in,
  input  logic             clear_count,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic             stuck
);

  localparam int FILL_W = $clog2(LFSR_W + 1);
  localparam int GOOD_W = $clog2(LOCK_CNT + 1);
  localparam int CERR_W = $clog2(LOSS_ERRS + 1);

  state_t            state_q, state_d;
  logic [LFSR_W:1]   sh_q, sh_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [GOOD_W-1:0] good_q, good_d;
  logic [CERR_W-1:0] cerr_q, cerr_d;
  logic [ERR_W-1:0]  err_count_d;
  logic              err_pulse_d;
  logic              locked_d;
  logic              stuck_d;
  logic              pred;
  logic              mismatch;

  assign pred     = lfsr10_next_bit(sh_q);
  assign mismatch = (bit_in != pred);

  // NOTE: every signal written here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    sh_d        = sh_q;
    fill_d      = fill_q;
    good_d      = good_q;
    cerr_d      = cerr_q;
    err_count_d = err_count;
    err_pulse_d = 1'b0;

    if (bit_valid) begin
      unique case (state_q)
        FILL: begin
          sh_d = {sh_q[LFSR_W-1:1], bit_in};
          if (fill_q == FILL_W'(LFSR_W - 1)) begin
            fill_d  = '0;
            good_d  = '0;
            state_d = VERIFY;
          end else begin
            fill_d = fill_q + 1'b1;
          end
        end

        VERIFY: begin
          // Keep shifting the received bit so a mismatch simply resynchronises.
          sh_d = {sh_q[LFSR_W-1:1], bit_in};
          if ((&sh_q) || mismatch) begin
            good_d = '0;
          end else if (good_q == GOOD_W'(LOCK_CNT - 1)) begin
            good_d  = '0;
            cerr_d  = '0;
            state_d = LOCKED;
          end else begin
            good_d = good_q + 1'b1;
          end
        end

        LOCKED: begin
          // Free-run on the prediction so one flipped bit costs exactly one error.
          sh_d = {sh_q[LFSR_W-1:1], pred};
          if (mismatch) begin
            err_pulse_d = 1'b1;
            if (!(&err_count)) err_count_d = err_count + 1'b1;
            if (cerr_q == CERR_W'(LOSS_ERRS - 1)) begin
              cerr_d  = '0;
              fill_d  = '0;
              state_d = FILL;
            end else begin
              cerr_d = cerr_q + 1'b1;
            end
          end else begin
            cerr_d = '0;
          end
        end

        default: begin
          fill_d  = '0;
          state_d = FILL;
        end
      endcase
    end

    if (clear_count) err_count_d = '0;

    locked_d = (state_d == LOCKED);
    stuck_d  = (&sh_d) && (state_d != FILL);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FILL;
      sh_q      <= '0;
      fill_q    <= '0;
      good_q    <= '0;
      cerr_q    <= '0;
      err_count <= '0;
      err_pulse <= 1'b0;
      locked    <= 1'b0;
      stuck     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sh_q      <= sh_d;
      fill_q    <= fill_d;
      good_q    <= good_d;
      cerr_q    <= cerr_d;
      err_count <= err_count_d;
      err_pulse <= err_pulse_d;
      locked    <= locked_d;
      stuck     <= stuck_d;
    end
  end

endmodule
